mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported 16-bit memory (memory1c-class) between the CPU's instruction-fetch
//  requester (read-only) and data requester (LW/SW). Arbitrates, sequences the memory access over a
//  fixed latency, and returns a one-cycle done pulse with read data. The CPU stalls on ~done.
//  Sits between the fetch/D-mem stages and the unified memory instance.
// PARAMETERS
//  ADDR_W      16  address width (word address)
//  DATA_W      16  data width
//  MEM_LAT     1   cycles mem_en/addr are held before rdata is sampled (>=1)
//  STARVE_MAX  4   consecutive lost arbitrations before fetch is forced (used only with macro)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request; held high until if_done
//  if_addr    in   ADDR_W  fetch address (PC); stable while if_req
//  if_done    out  1       one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction
//  d_req      in   1       data request; held high until d_done
//  d_wr       in   1       1=store, 0=load; stable while d_req
//  d_addr     in   ADDR_W  data address (ALU result)
//  d_wdata    in   DATA_W  store data
//  d_done     out  1       one-cycle pulse: data access complete, d_rdata valid for loads
//  d_rdata    out  DATA_W  load data
//  busy       out  1       high in any state other than IDLE
//  mem_en     out  1       memory enable
//  mem_wr     out  1       memory write strobe
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (if_done, d_done, *_rdata, busy, mem_*); starvation count 0.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE. Requests sampled only in IDLE.
//  - IDLE: if d_req or if_req, pick winner (d_req wins ties); latch winner id, addr, wr (fetch: 0),
//    wdata into registers; load latency counter with MEM_LAT-1; go ACCESS. No req: stay IDLE.
//  - ACCESS: mem_en=1, mem_addr/mem_wdata/mem_wr driven from latched registers (mem_wr=1 only for
//    store). Counter decrements each cycle; at 0, capture mem_rdata into winner's rdata register,
//    go RESP. mem_* are 0 outside ACCESS.
//  - RESP: winner's done=1 for exactly this cycle; other done=0; go IDLE. Loser's rdata unchanged.
//  - Latency: req high in IDLE at cycle T -> done high at T+MEM_LAT+1. Back-to-back throughput: one
//    access per MEM_LAT+2 cycles.
//  - Requester dropping req mid-access does not abort; done still pulses. Req still high in IDLE
//    after its done is a new request.
//  - Store: d_done pulses, d_rdata holds the value captured from mem_rdata (don't-care for CPU).
//  - Reset mid-operation: immediate return to IDLE, no done pulse; an in-flight store may or may not
//    have been written; CPU restarts at PC 0 so this is acceptable.
//  - Latched address/data are ADDR_W/DATA_W bit-exact; no translation or alignment.
// CONFIGURATION
//  - MEM_ARB_FAIRNESS_EN defined: counter increments (saturating at STARVE_MAX) each IDLE arbitration
//    where if_req=1 and data wins; when count==STARVE_MAX and if_req=1, fetch wins even if d_req=1.
//    Counter clears when fetch is granted or when if_req=0 in IDLE.
//  - Not defined: strict data priority; no counter logic; STARVE_MAX unused.
// STRUCTURE
//  - mem_arb_pkg: state enum {IDLE, ACCESS, RESP}; requester id constants REQ_IF=1'b0, REQ_D=1'b1.
//  - Sub-module mem_arb_starve_ctr (saturating counter + force flag), instantiated only under
//    MEM_ARB_FAIRNESS_EN. Latency counter and FSM stay in top.
// TESTING
//  1. Reset: rst_n low mid-ACCESS of a store -> next cycle all outputs 0, busy=0, no done pulse.
//  2. Fetch only, MEM_LAT=1, if_addr=16'h0004, mem returns 16'hA123 -> if_done at T+2,
//     if_rdata=16'hA123, mem_wr=0 throughout.
//  3. Simultaneous if_req and d_req (store 16'h00FF to 16'h0010) -> data first: mem_wr=1,
//     mem_addr=16'h0010 in ACCESS, d_done T+2; fetch granted next IDLE, if_done T+5.
//  4. Load then MEM_LAT=3, d_addr=16'h0020 -> mem_en held 3 cycles with stable addr, d_done at T+4.
//  5. MEM_ARB_FAIRNESS_EN, STARVE_MAX=4, d_req and if_req held continuously -> 4 data grants then
//     1 fetch grant, repeating; without macro -> fetch never granted.
//  6. d_req dropped during ACCESS -> d_done still pulses once; no second access issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Requester ids held in the winner register.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation counter: counts consecutive IDLE arbitrations lost by fetch to data and
// raises force_if_o once fetch has lost STARVE_MAX times in a row while still requesting.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic force_if_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] count_q, count_d;
  logic            at_max;

  assign at_max     = (count_q == CntW'(STARVE_MAX));
  assign force_if_o = if_req_i && at_max;

  // Next count: only arbitration cycles (IDLE) move the counter.
  always_comb begin
    count_d = count_q;
    if (idle_i) begin
      if (!if_req_i) begin
        count_d = '0;
      end else if (force_if_o || !d_req_i) begin
        // Fetch is granted this cycle.
        count_d = '0;
      end else if (!at_max) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (read-only) and data
// (load/store) requesters. Data wins ties. Optional fetch anti-starvation is enabled by
// defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        state_q, state_d;
  logic              winner_q, winner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              force_if;

`ifdef MEM_ARB_FAIRNESS_EN
  logic idle;
  assign idle = (state_q == IDLE);

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle_i    (idle),
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .force_if_o(force_if)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
  assign force_if          = 1'b0;
`endif

  // Next-state, request latching, read-data capture and outputs.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_done   = 1'b0;
    d_done    = 1'b0;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (d_req && !force_if) begin
          winner_d = REQ_D;
          wr_d     = d_wr;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          lat_d    = LatW'(MEM_LAT - 1);
          state_d  = ACCESS;
        end else if (if_req) begin
          winner_d = REQ_IF;
          wr_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          lat_d    = LatW'(MEM_LAT - 1);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_wr    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (lat_q == '0) begin
          if (winner_q == REQ_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP: begin
        if_done = (winner_q == REQ_IF);
        d_done  = (winner_q == REQ_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winner_q   <= REQ_IF;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule
